// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline package for the ID/EX stage.
// Holds the ALU operation width and the operand-forwarding select codes
// driven to the EX stage operand multiplexers.
package id_ex_stage_pkg;

    localparam int ALUOP_W = 4;

    // Select codes for the EX operand multiplexers.
    localparam logic [1:0] FWD_RF    = 2'b00;  // operand straight from the register file
    localparam logic [1:0] FWD_MEMWB = 2'b01;  // bypass from the MEM/WB result
    localparam logic [1:0] FWD_EXMEM = 2'b10;  // bypass from the EX/MEM result

    // Select code for one source register.
    // The EX/MEM producer is younger than the MEM/WB one, so it is checked first.
    // Register 0 is hard-wired to zero and is never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic       valid,
        input logic [4:0] src,
        input logic       exmem_regwrite,
        input logic [4:0] exmem_rd,
        input logic       memwb_regwrite,
        input logic [4:0] memwb_rd
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (valid) begin
            if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == src)) begin
                sel = FWD_EXMEM;
            end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == src)) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// forward_unit: combinational operand-forwarding decision for the EX stage.
// Ports:
//   valid           - the ID/EX stage holds a real instruction
//   rs, rt          - registered source specifiers of that instruction
//   exmem_regwrite  - EX/MEM instruction writes the register file
//   exmem_rd        - EX/MEM destination register
//   memwb_regwrite  - MEM/WB instruction writes the register file
//   memwb_rd        - MEM/WB destination register
//   forward_a       - select code for operand A (from rs)
//   forward_b       - select code for operand B (from rt)
module forward_unit
    import id_ex_stage_pkg::*;
(
    input  logic       valid,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       exmem_regwrite,
    input  logic [4:0] exmem_rd,
    input  logic       memwb_regwrite,
    input  logic [4:0] memwb_rd,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b
);

    always_comb begin
        forward_a = fwd_select(valid, rs, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
        forward_b = fwd_select(valid, rt, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with stall, flush and forwarding select.
// Ports:
//   Clk, Rst                 - clock and synchronous active-high reset
//   Stall                    - hold every register this cycle
//   Flush                    - load a bubble (all zero, Valid_out=0); beats Stall
//   *_in                     - operands, immediates, specifiers and control from ID
//   EXMEM_RegWrite/Rd        - destination of the instruction in EX/MEM
//   MEMWB_RegWrite/Rd        - destination of the instruction in MEM/WB
//   *_out                    - registered copies of the *_in signals
//   WriteReg_out             - registered destination (Rd when RegDst, else Rt)
//   Valid_out                - stage holds a real instruction
//   ForwardA, ForwardB       - EX operand mux select codes
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int ALUOP_W = id_ex_stage_pkg::ALUOP_W
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Stall,
    input  logic               Flush,
    input  logic [31:0]        ReadData1_in,
    input  logic [31:0]        ReadData2_in,
    input  logic [31:0]        SignExt_in,
    input  logic [31:0]        PCPlus4_in,
    input  logic [4:0]         Rs_in,
    input  logic [4:0]         Rt_in,
    input  logic [4:0]         Rd_in,
    input  logic               RegWrite_in,
    input  logic               MemToReg_in,
    input  logic               MemRead_in,
    input  logic               MemWrite_in,
    input  logic               ALUSrc_in,
    input  logic               RegDst_in,
    input  logic [ALUOP_W-1:0] ALUOp_in,
    input  logic               EXMEM_RegWrite,
    input  logic [4:0]         EXMEM_Rd,
    input  logic               MEMWB_RegWrite,
    input  logic [4:0]         MEMWB_Rd,
    output logic [31:0]        ReadData1_out,
    output logic [31:0]        ReadData2_out,
    output logic [31:0]        SignExt_out,
    output logic [31:0]        PCPlus4_out,
    output logic [4:0]         Rs_out,
    output logic [4:0]         Rt_out,
    output logic [4:0]         Rd_out,
    output logic               RegWrite_out,
    output logic               MemToReg_out,
    output logic               MemRead_out,
    output logic               MemWrite_out,
    output logic               ALUSrc_out,
    output logic               RegDst_out,
    output logic [ALUOP_W-1:0] ALUOp_out,
    output logic [4:0]         WriteReg_out,
    output logic               Valid_out,
    output logic [1:0]         ForwardA,
    output logic [1:0]         ForwardB
);

    always_ff @(posedge Clk) begin
        if (Rst || Flush) begin
            // Reset and flush both leave a zeroed bubble behind.
            ReadData1_out <= '0;
            ReadData2_out <= '0;
            SignExt_out   <= '0;
            PCPlus4_out   <= '0;
            Rs_out        <= '0;
            Rt_out        <= '0;
            Rd_out        <= '0;
            RegWrite_out  <= 1'b0;
            MemToReg_out  <= 1'b0;
            MemRead_out   <= 1'b0;
            MemWrite_out  <= 1'b0;
            ALUSrc_out    <= 1'b0;
            RegDst_out    <= 1'b0;
            ALUOp_out     <= '0;
            WriteReg_out  <= '0;
            Valid_out     <= 1'b0;
        end else if (!Stall) begin
            ReadData1_out <= ReadData1_in;
            ReadData2_out <= ReadData2_in;
            SignExt_out   <= SignExt_in;
            PCPlus4_out   <= PCPlus4_in;
            Rs_out        <= Rs_in;
            Rt_out        <= Rt_in;
            Rd_out        <= Rd_in;
            RegWrite_out  <= RegWrite_in;
            MemToReg_out  <= MemToReg_in;
            MemRead_out   <= MemRead_in;
            MemWrite_out  <= MemWrite_in;
            ALUSrc_out    <= ALUSrc_in;
            RegDst_out    <= RegDst_in;
            ALUOp_out     <= ALUOp_in;
            WriteReg_out  <= RegDst_in ? Rd_in : Rt_in;
            Valid_out     <= 1'b1;
        end
    end

    forward_unit u_forward_unit (
        .valid          (Valid_out),
        .rs             (Rs_out),
        .rt             (Rt_out),
        .exmem_regwrite (EXMEM_RegWrite),
        .exmem_rd       (EXMEM_Rd),
        .memwb_regwrite (MEMWB_RegWrite),
        .memwb_rd       (MEMWB_Rd),
        .forward_a      (ForwardA),
        .forward_b      (ForwardB)
    );

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int AW = 4;

    logic          Clk = 1'b0;
    logic          Rst, Stall, Flush;
    logic [31:0]   ReadData1_in, ReadData2_in, SignExt_in, PCPlus4_in;
    logic [4:0]    Rs_in, Rt_in, Rd_in;
    logic          RegWrite_in, MemToReg_in, MemRead_in, MemWrite_in, ALUSrc_in, RegDst_in;
    logic [AW-1:0] ALUOp_in;
    logic          EXMEM_RegWrite, MEMWB_RegWrite;
    logic [4:0]    EXMEM_Rd, MEMWB_Rd;
    logic [31:0]   ReadData1_out, ReadData2_out, SignExt_out, PCPlus4_out;
    logic [4:0]    Rs_out, Rt_out, Rd_out, WriteReg_out;
    logic          RegWrite_out, MemToReg_out, MemRead_out, MemWrite_out, ALUSrc_out, RegDst_out;
    logic [AW-1:0] ALUOp_out;
    logic          Valid_out;
    logic [1:0]    ForwardA, ForwardB;

    always #5 Clk = ~Clk;

    id_ex_stage #(.ALUOP_W(AW)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
        .ReadData1_in(ReadData1_in), .ReadData2_in(ReadData2_in),
        .SignExt_in(SignExt_in), .PCPlus4_in(PCPlus4_in),
        .Rs_in(Rs_in), .Rt_in(Rt_in), .Rd_in(Rd_in),
        .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .ALUSrc_in(ALUSrc_in), .RegDst_in(RegDst_in),
        .ALUOp_in(ALUOp_in),
        .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_Rd(EXMEM_Rd),
        .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_Rd(MEMWB_Rd),
        .ReadData1_out(ReadData1_out), .ReadData2_out(ReadData2_out),
        .SignExt_out(SignExt_out), .PCPlus4_out(PCPlus4_out),
        .Rs_out(Rs_out), .Rt_out(Rt_out), .Rd_out(Rd_out),
        .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .ALUSrc_out(ALUSrc_out), .RegDst_out(RegDst_out),
        .ALUOp_out(ALUOp_out), .WriteReg_out(WriteReg_out), .Valid_out(Valid_out),
        .ForwardA(ForwardA), .ForwardB(ForwardB)
    );

    // Reference contents of the stage register.
    typedef struct packed {
        logic [31:0]   rd1, rd2, sext, pc4;
        logic [4:0]    rs, rt, rd;
        logic          regwrite, memtoreg, memread, memwrite, alusrc, regdst;
        logic [AW-1:0] aluop;
        logic [4:0]    wreg;
        logic          valid;
    } stage_t;

    stage_t m = '0;
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_exp(input logic [4:0] src);
        if (!m.valid) return 2'b00;
        if (EXMEM_RegWrite && EXMEM_Rd != 0 && EXMEM_Rd == src) return 2'b10;
        if (MEMWB_RegWrite && MEMWB_Rd != 0 && MEMWB_Rd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_fwd(input string tag);
        check({tag, "_fwdA"}, 32'(ForwardA), 32'(fwd_exp(m.rs)));
        check({tag, "_fwdB"}, 32'(ForwardB), 32'(fwd_exp(m.rt)));
        check({tag, "_no11"}, 32'(ForwardA == 2'b11 || ForwardB == 2'b11), 32'd0);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_rd1"},   ReadData1_out,       m.rd1);
        check({tag, "_rd2"},   ReadData2_out,       m.rd2);
        check({tag, "_sext"},  SignExt_out,         m.sext);
        check({tag, "_pc4"},   PCPlus4_out,         m.pc4);
        check({tag, "_rs"},    32'(Rs_out),         32'(m.rs));
        check({tag, "_rt"},    32'(Rt_out),         32'(m.rt));
        check({tag, "_rd"},    32'(Rd_out),         32'(m.rd));
        check({tag, "_ctl"},   32'({RegWrite_out, MemToReg_out, MemRead_out, MemWrite_out, ALUSrc_out, RegDst_out}),
                               32'({m.regwrite, m.memtoreg, m.memread, m.memwrite, m.alusrc, m.regdst}));
        check({tag, "_aluop"}, 32'(ALUOp_out),      32'(m.aluop));
        check({tag, "_wreg"},  32'(WriteReg_out),   32'(m.wreg));
        check({tag, "_valid"}, 32'(Valid_out),      32'(m.valid));
    endtask

    // One clock: check forwarding on the current inputs, clock, advance the model, check registers.
    task automatic tick(input string tag, input bit pre_check);
        #1;
        if (pre_check) check_fwd({tag, "_pre"});
        @(posedge Clk);
        if (Rst || Flush) begin
            m = '0;
        end else if (!Stall) begin
            m.rd1 = ReadData1_in;   m.rd2 = ReadData2_in;
            m.sext = SignExt_in;    m.pc4 = PCPlus4_in;
            m.rs = Rs_in;           m.rt = Rt_in;          m.rd = Rd_in;
            m.regwrite = RegWrite_in; m.memtoreg = MemToReg_in; m.memread = MemRead_in;
            m.memwrite = MemWrite_in; m.alusrc = ALUSrc_in;     m.regdst = RegDst_in;
            m.aluop = ALUOp_in;
            m.wreg = RegDst_in ? Rd_in : Rt_in;
            m.valid = 1'b1;
        end
        #1;
        check_regs(tag);
        check_fwd(tag);
    endtask

    task automatic rand_payload();
        ReadData1_in = $urandom; ReadData2_in = $urandom;
        SignExt_in = $urandom;   PCPlus4_in = $urandom;
        Rs_in = 5'($urandom); Rt_in = 5'($urandom); Rd_in = 5'($urandom);
        {RegWrite_in, MemToReg_in, MemRead_in, MemWrite_in, ALUSrc_in, RegDst_in} = 6'($urandom);
        ALUOp_in = AW'($urandom);
    endtask

    function automatic logic [4:0] pick_rd();
        case ($urandom_range(0, 3))
            0: return m.rs;
            1: return m.rt;
            2: return 5'd0;
            default: return 5'($urandom);
        endcase
    endfunction

    initial begin
        Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        ReadData1_in = '0; ReadData2_in = '0; SignExt_in = '0; PCPlus4_in = '0;
        Rs_in = '0; Rt_in = '0; Rd_in = '0;
        {RegWrite_in, MemToReg_in, MemRead_in, MemWrite_in, ALUSrc_in, RegDst_in} = '0;
        ALUOp_in = '0;
        EXMEM_RegWrite = 1'b0; EXMEM_Rd = '0; MEMWB_RegWrite = 1'b0; MEMWB_Rd = '0;

        tick("reset", 1'b0);
        check("reset_valid", 32'(Valid_out), 32'd0);

        // Single load.
        Rst = 1'b0;
        Rs_in = 5'd3; ReadData1_in = 32'hA5A5_0001; RegWrite_in = 1'b1;
        tick("load", 1'b1);
        check("load_rs", 32'(Rs_out), 32'd3);
        check("load_rd1", ReadData1_out, 32'hA5A5_0001);
        check("load_regwrite", 32'(RegWrite_out), 32'd1);
        check("load_valid", 32'(Valid_out), 32'd1);

        // Stall for two cycles while the inputs move.
        Stall = 1'b1;
        Rs_in = 5'd7; ReadData1_in = 32'h1234_5678; RegWrite_in = 1'b0;
        tick("stall1", 1'b1);
        ReadData1_in = 32'h8765_4321;
        tick("stall2", 1'b1);
        check("stall_rs_held", 32'(Rs_out), 32'd3);
        check("stall_rd1_held", ReadData1_out, 32'hA5A5_0001);
        Stall = 1'b0;
        tick("unstall", 1'b1);
        check("unstall_rs", 32'(Rs_out), 32'd7);
        check("unstall_rd1", ReadData1_out, 32'h8765_4321);

        // Flush wins over stall.
        Flush = 1'b1; Stall = 1'b1; RegWrite_in = 1'b1; MemRead_in = 1'b1;
        EXMEM_RegWrite = 1'b1; EXMEM_Rd = 5'd7;
        tick("flush", 1'b1);
        check("flush_regwrite", 32'(RegWrite_out), 32'd0);
        check("flush_memread", 32'(MemRead_out), 32'd0);
        check("flush_valid", 32'(Valid_out), 32'd0);
        check("flush_fwdA", 32'(ForwardA), 32'd0);
        check("flush_fwdB", 32'(ForwardB), 32'd0);

        // EX/MEM beats MEM/WB; then MEM/WB alone.
        Flush = 1'b0; Stall = 1'b0; Rs_in = 5'd5; Rt_in = 5'd0; RegDst_in = 1'b1; Rd_in = 5'd9;
        EXMEM_RegWrite = 1'b0; EXMEM_Rd = 5'd0;
        tick("fwd_load", 1'b1);
        check("fwd_wreg_rd", 32'(WriteReg_out), 32'd9);
        EXMEM_RegWrite = 1'b1; EXMEM_Rd = 5'd5; MEMWB_RegWrite = 1'b1; MEMWB_Rd = 5'd5;
        #1;
        check("fwd_both", 32'(ForwardA), 32'b10);
        EXMEM_RegWrite = 1'b0;
        #1;
        check("fwd_memwb", 32'(ForwardA), 32'b01);

        // Register 0 never forwards.
        EXMEM_RegWrite = 1'b1; EXMEM_Rd = 5'd0; MEMWB_RegWrite = 1'b0;
        #1;
        check("fwd_r0", 32'(ForwardB), 32'b00);

        // Reset during stall clears the stage.
        rand_payload();
        tick("pre_rst", 1'b1);
        Stall = 1'b1; Rst = 1'b1;
        tick("rst_stall", 1'b1);
        check("rst_stall_valid", 32'(Valid_out), 32'd0);
        check("rst_stall_rd1", ReadData1_out, 32'd0);
        check("rst_stall_wreg", 32'(WriteReg_out), 32'd0);
        Rst = 1'b0; Stall = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rand_payload();
            Rst   = ($urandom_range(0, 39) == 0);
            Flush = ($urandom_range(0, 9) == 0);
            Stall = ($urandom_range(0, 3) == 0);
            EXMEM_RegWrite = 1'($urandom); EXMEM_Rd = pick_rd();
            MEMWB_RegWrite = 1'($urandom); MEMWB_Rd = pick_rd();
            tick("rnd", 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter ALUOP_W, default 4, width of the ALU operation code.
REQ-002 The block SHALL have port Clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Rst, input, 1, synchronous, active-high reset.
REQ-004 The block SHALL have port Stall, input, 1, hold all registered state this cycle.
REQ-005 The block SHALL have port Flush, input, 1, load a bubble this cycle.
REQ-006 The block SHALL have ports ReadData1_in and ReadData2_in, input, 32, register-file operands from ID.
REQ-007 The block SHALL have ports SignExt_in and PCPlus4_in, input, 32, immediate and PC+4 from ID.
REQ-008 The block SHALL have ports Rs_in, Rt_in and Rd_in, input, 5, register specifiers from ID.
REQ-009 The block SHALL have ports RegWrite_in, MemToReg_in, MemRead_in, MemWrite_in, ALUSrc_in and RegDst_in, input, 1 each, control bits from ID.
REQ-010 The block SHALL have port ALUOp_in, input, ALUOP_W, ALU operation from ID.
REQ-011 The block SHALL have ports EXMEM_RegWrite, input, 1, and EXMEM_Rd, input, 5, the EX/MEM destination.
REQ-012 The block SHALL have ports MEMWB_RegWrite, input, 1, and MEMWB_Rd, input, 5, the MEM/WB destination.
REQ-013 The block SHALL have an output, with suffix _out, for each registered copy of REQ-006..REQ-010, at the same width as its input.
REQ-014 The block SHALL have port WriteReg_out, output, 5, registered destination register.
REQ-015 The block SHALL have port Valid_out, output, 1, set when the stage holds a real instruction.
REQ-016 The block SHALL have ports ForwardA and ForwardB, output, 2 each, select codes for the EX operand muxes.

Function
REQ-017 Register update priority on each rising Clk SHALL be Rst, then Flush, then Stall, then normal load.
REQ-018 On a normal load, every _out register SHALL capture its _in value, Valid_out SHALL become 1, and latency SHALL be exactly 1 cycle.
REQ-019 On a normal load, WriteReg_out SHALL capture Rd_in when RegDst_in=1, otherwise Rt_in.
REQ-020 On Stall=1 with Flush=0, all registers including Valid_out SHALL hold their value.
REQ-021 On Flush=1, all registers SHALL be zeroed and Valid_out set to 0, regardless of Stall.
REQ-022 ForwardA SHALL be combinational from registered state and the EX/MEM and MEM/WB inputs: 2'b10 if EXMEM_RegWrite=1, EXMEM_Rd!=0 and EXMEM_Rd==Rs_out; else 2'b01 if MEMWB_RegWrite=1, MEMWB_Rd!=0 and MEMWB_Rd==Rs_out; else 2'b00.
REQ-023 ForwardB SHALL follow the same rule as REQ-022 using Rt_out.
REQ-024 EX/MEM priority over MEM/WB SHALL apply when both match (most recent producer wins).
REQ-025 ForwardA and ForwardB SHALL be 2'b00 whenever Valid_out=0.
REQ-026 Code 2'b11 SHALL never be produced.

Reset
REQ-027 On Rst=1 at a rising Clk, all _out registers, WriteReg_out and Valid_out SHALL become 0, which forces ForwardA and ForwardB to 2'b00.
REQ-028 Rst SHALL override Stall and Flush, and a reset asserted while Stall is active SHALL still clear the stage.

Structure
REQ-029 The forward-code constants (FWD_RF=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10) and ALUOP_W SHALL live in the shared pipeline package.
REQ-030 The forwarding comparison logic SHALL be one sub-module, forward_unit, instantiated once and feeding ForwardA and ForwardB.

Verification
REQ-031 Load Rs_in=3, ReadData1_in=32'hA5A5_0001 and RegWrite_in=1 -> next cycle Rs_out=3, ReadData1_out=32'hA5A5_0001, RegWrite_out=1 and Valid_out=1.
REQ-032 Hold Stall=1 for 2 cycles while the inputs change -> the outputs keep their previous values, then take the new values one cycle after Stall drops.
REQ-033 Assert Flush=1 and Stall=1 together with RegWrite_in=1 -> next cycle all control outputs are 0, Valid_out=0 and ForwardA=ForwardB=00.
REQ-034 With Rs_out=5, drive EXMEM_RegWrite=1, EXMEM_Rd=5, MEMWB_RegWrite=1 and MEMWB_Rd=5 -> ForwardA=10; then drop EXMEM_RegWrite -> ForwardA=01.
REQ-035 With Rt_out=0 and EXMEM_RegWrite=1, EXMEM_Rd=0 -> ForwardB=00.
REQ-036 Assert Rst=1 mid-stream while Stall=1 -> next cycle all outputs are 0 and Valid_out=0.
